// File: rtl/square_pkg.sv
// Shared types for the square_grid board game block: cell encoding,
// FSM state encoding and the player-to-cell mapping.
package square_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        WIN  = 2'b01,
        DRAW = 2'b10
    } state_t;

    // Map the requesting player bit onto the value written into a cell.
    function automatic cell_t player_cell(input logic pl);
        cell_t v;
        if (pl == 1'b1) begin
            v = P1;
        end else begin
            v = P0;
        end
        return v;
    endfunction

endpackage

// File: rtl/square_grid_if.sv
// Move request / board status bundle between a game controller and square_grid.
interface square_grid_if #(
    parameter int N      = 3,
    parameter int CODE_W = $clog2(N*N)
);
    logic [CODE_W-1:0] code;
    logic              sel;
    logic              pl;
    logic              clr;
    logic [2*N*N-1:0]  out;
    logic              turn;
    logic              move_ok;
    logic              move_err;
    logic [1:0]        winner;
    logic              done;

    modport master (
        output code, sel, pl, clr,
        input  out, turn, move_ok, move_err, winner, done
    );

    modport slave (
        input  code, sel, pl, clr,
        output out, turn, move_ok, move_err, winner, done
    );
endinterface

// File: rtl/square_cell.sv
// One board cell: a 2-bit owner register that recognises its own index and
// takes the mover's value when the grid accepts a move addressed to it.
module square_cell
    import square_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_we,
    input  cell_t             i_val,
    input  logic              i_clr,
    output cell_t             o_cell,
    output logic              o_hit,
    output logic              o_occ
);

    cell_t r_cell;
    logic  w_hit;

    // Address decode of this cell's own index.
    always_comb begin
        w_hit = (i_code == CODE_W'(IDX));
    end

    // Owner register: cleared by new game, written only on an accepted move here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cell <= EMPTY;
        end else if (i_clr) begin
            r_cell <= EMPTY;
        end else if (i_we && w_hit) begin
            r_cell <= i_val;
        end else begin
            r_cell <= r_cell;
        end
    end

    assign o_cell = r_cell;
    assign o_hit  = w_hit;
    assign o_occ  = (r_cell != EMPTY);

endmodule

// File: rtl/square_grid.sv
// N x N two-player line game. Validates each move request, writes the cell,
// alternates turns and detects row/column/diagonal wins or a full-board draw.
module square_grid
    import square_pkg::*;
#(
    parameter int N      = 3,
    parameter int CODE_W = $clog2(N*N)
) (
    input  logic           clk,
    input  logic           rst,
    square_grid_if.slave   bus
);

    localparam int NN    = N*N;
    localparam int CNT_W = $clog2(NN+1);

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_turn;
    logic             r_ok;
    logic             r_err;
    logic             r_done;
    logic [1:0]       r_winner;
    logic [CNT_W-1:0] r_cnt;

    cell_t            w_cell [NN];
    cell_t            w_nb   [NN];
    logic [NN-1:0]    w_hit;
    logic [NN-1:0]    w_occ;
    logic [NN-1:0]    w_own;
    logic [NN-1:0]    w_own_t;
    logic [N-1:0]     w_diag;
    logic [N-1:0]     w_anti;
    logic [N-1:0]     w_row_win;
    logic [N-1:0]     w_col_win;
    logic [2*NN-1:0]  w_out;
    cell_t            w_mover;
    logic             w_in_range;
    logic             w_occ_sel;
    logic             w_legal;
    logic             w_illegal;
    logic             w_win;
    logic             w_last;

    assign w_mover   = player_cell(bus.pl);
    assign w_occ_sel = |(w_hit & w_occ);

    // Cells, post-write board view and ownership flags for the mover.
    for (genvar i = 0; i < NN; i++) begin : g_cell
        square_cell #(
            .CODE_W (CODE_W),
            .IDX    (i)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_code (bus.code),
            .i_we   (w_legal),
            .i_val  (w_mover),
            .i_clr  (bus.clr),
            .o_cell (w_cell[i]),
            .o_hit  (w_hit[i]),
            .o_occ  (w_occ[i])
        );
        assign w_nb[i]             = (w_legal && w_hit[i]) ? w_mover : w_cell[i];
        assign w_own[i]            = (w_nb[i] == w_mover);
        assign w_out[2*i +: 2]     = w_cell[i];
    end

    // Row/column reductions; columns use a transposed copy of the ownership map.
    for (genvar r = 0; r < N; r++) begin : g_line
        for (genvar c = 0; c < N; c++) begin : g_tr
            assign w_own_t[c*N + r] = w_own[r*N + c];
        end
        assign w_row_win[r] = &w_own[r*N +: N];
        assign w_col_win[r] = &w_own_t[r*N +: N];
        assign w_diag[r]    = w_own[r*N + r];
        assign w_anti[r]    = w_own[r*N + (N-1-r)];
    end

    // Move legality, win and last-cell qualification for the current request.
    always_comb begin
        w_in_range = (int'(bus.code) < NN);
        w_legal    = (r_state == PLAY) && bus.sel && !bus.clr && w_in_range &&
                     !w_occ_sel && (bus.pl == r_turn);
        w_illegal  = bus.sel && !bus.clr && !w_legal;
        w_win      = w_legal && ((|w_row_win) || (|w_col_win) || (&w_diag) || (&w_anti));
        w_last     = w_legal && (r_cnt == CNT_W'(NN-1));
    end

    // FSM next state: a win outranks a full board; clr always returns to PLAY.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            PLAY: begin
                if (bus.clr) begin
                    w_state_nx = PLAY;
                end else if (w_win) begin
                    w_state_nx = WIN;
                end else if (w_last) begin
                    w_state_nx = DRAW;
                end else begin
                    w_state_nx = PLAY;
                end
            end
            WIN, DRAW: begin
                if (bus.clr) begin
                    w_state_nx = PLAY;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: w_state_nx = PLAY;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Turn, winner, move counter, result pulses and done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_turn   <= 1'b0;
            r_winner <= 2'b00;
            r_cnt    <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.clr) begin
            r_turn   <= 1'b0;
            r_winner <= 2'b00;
            r_cnt    <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ok   <= w_legal;
            r_err  <= w_illegal;
            r_done <= (w_state_nx != PLAY);
            if (w_legal) begin
                r_turn <= ~r_turn;
            end else begin
                r_turn <= r_turn;
            end
            if (w_win) begin
                r_winner <= w_mover;
            end else begin
                r_winner <= r_winner;
            end
            if (w_legal && (r_cnt < CNT_W'(NN))) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign bus.out      = w_out;
    assign bus.turn     = r_turn;
    assign bus.move_ok  = r_ok;
    assign bus.move_err = r_err;
    assign bus.winner   = r_winner;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_square_grid.sv
// Self-checking bench for square_grid (N=3): table of move vectors with a
// scoreboard queue, plus hand-written reset corner sequences.
module tb_square_grid;

    localparam int N      = 3;
    localparam int CODE_W = $clog2(N*N);

    typedef struct {
        logic [CODE_W-1:0] code;
        logic              sel;
        logic              pl;
        logic              clr;
        logic              ok;
        logic              err;
        logic              turn;
        logic [1:0]        winner;
        logic              done;
    } vec_t;

    typedef struct {
        logic              ok;
        logic              err;
        logic [2*N*N-1:0]  out;
        logic              turn;
        logic [1:0]        winner;
        logic              done;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t tbl [$];
    exp_t exp_q [$];
    logic [2*N*N-1:0] model_board;

    square_grid_if #(.N(N), .CODE_W(CODE_W)) bus ();

    square_grid #(.N(N), .CODE_W(CODE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int code, input bit sel, input bit pl, input bit clr,
                       input bit ok, input bit err, input bit turn,
                       input int winner, input bit done);
        vec_t v;
        v.code   = CODE_W'(code);
        v.sel    = sel;
        v.pl     = pl;
        v.clr    = clr;
        v.ok     = ok;
        v.err    = err;
        v.turn   = turn;
        v.winner = 2'(winner);
        v.done   = done;
        tbl.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out"},      64'(bus.out),      64'd0);
        check({tag, ".turn"},     64'(bus.turn),     64'd0);
        check({tag, ".move_ok"},  64'(bus.move_ok),  64'd0);
        check({tag, ".move_err"}, 64'(bus.move_err), 64'd0);
        check({tag, ".winner"},   64'(bus.winner),   64'd0);
        check({tag, ".done"},     64'(bus.done),     64'd0);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        n_checks    = 0;
        n_fail      = 0;
        model_board = '0;
        bus.code = '0;
        bus.sel  = 1'b0;
        bus.pl   = 1'b0;
        bus.clr  = 1'b0;
        rst      = 1'b0;

        // Basic moves, rejects (occupied, out of range, wrong player), idle, clr.
        add(4, 1, 0, 0, 1, 0, 1, 0, 0);
        add(4, 1, 1, 0, 0, 1, 1, 0, 0);
        add(9, 1, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // P0 wins on the top row; further moves rejected; clr beats sel.
        add(0, 1, 0, 0, 1, 0, 1, 0, 0);
        add(3, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0);
        add(4, 1, 1, 0, 1, 0, 0, 0, 0);
        add(2, 1, 0, 0, 1, 0, 1, 1, 1);
        add(5, 1, 1, 0, 0, 1, 1, 1, 1);
        add(5, 1, 0, 1, 0, 0, 0, 0, 0);
        // Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8.
        add(0, 1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(2, 1, 0, 0, 1, 0, 1, 0, 0);
        add(4, 1, 1, 0, 1, 0, 0, 0, 0);
        add(3, 1, 0, 0, 1, 0, 1, 0, 0);
        add(5, 1, 1, 0, 1, 0, 0, 0, 0);
        add(7, 1, 0, 0, 1, 0, 1, 0, 0);
        add(6, 1, 1, 0, 1, 0, 0, 0, 0);
        add(8, 1, 0, 0, 1, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        // Ninth move fills the board and completes the main diagonal: WIN.
        add(0, 1, 0, 0, 1, 0, 1, 0, 0);
        add(2, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0);
        add(3, 1, 1, 0, 1, 0, 0, 0, 0);
        add(4, 1, 0, 0, 1, 0, 1, 0, 0);
        add(6, 1, 1, 0, 1, 0, 0, 0, 0);
        add(5, 1, 0, 0, 1, 0, 1, 0, 0);
        add(7, 1, 1, 0, 1, 0, 0, 0, 0);
        add(8, 1, 0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Outputs during reset, before any clock edge.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            bus.code = tbl[k].code;
            bus.sel  = tbl[k].sel;
            bus.pl   = tbl[k].pl;
            bus.clr  = tbl[k].clr;
            if (tbl[k].clr) begin
                model_board = '0;
            end else if (tbl[k].ok) begin
                model_board[2*int'(tbl[k].code) +: 2] = tbl[k].pl ? 2'b10 : 2'b01;
            end
            e.ok     = tbl[k].ok;
            e.err    = tbl[k].err;
            e.out    = model_board;
            e.turn   = tbl[k].turn;
            e.winner = tbl[k].winner;
            e.done   = tbl[k].done;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got.ok     = bus.move_ok;
            got.err    = bus.move_err;
            got.out    = bus.out;
            got.turn   = bus.turn;
            got.winner = bus.winner;
            got.done   = bus.done;
            e = exp_q.pop_front();
            check($sformatf("v%0d.move_ok", k),  64'(got.ok),     64'(e.ok));
            check($sformatf("v%0d.move_err", k), 64'(got.err),    64'(e.err));
            check($sformatf("v%0d.out", k),      64'(got.out),    64'(e.out));
            check($sformatf("v%0d.turn", k),     64'(got.turn),   64'(e.turn));
            check($sformatf("v%0d.winner", k),   64'(got.winner), 64'(e.winner));
            check($sformatf("v%0d.done", k),     64'(got.done),   64'(e.done));
        end

        // Mid-game reset between edges: board discarded without a clock edge.
        @(negedge clk);
        bus.clr  = 1'b0;
        bus.sel  = 1'b1;
        bus.code = CODE_W'(4);
        bus.pl   = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst.move_ok", 64'(bus.move_ok), 64'd1);
        check("pre_rst.out",     64'(bus.out),     64'h100);
        bus.sel = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");

        // First edge after release samples inputs normally.
        bus.sel  = 1'b1;
        bus.code = CODE_W'(4);
        bus.pl   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.move_ok", 64'(bus.move_ok), 64'd1);
        check("post_rst.out",     64'(bus.out),     64'h100);
        check("post_rst.turn",    64'(bus.turn),    64'd1);
        @(negedge clk);
        bus.sel = 1'b0;
        @(posedge clk);
        #1;
        check("idle.move_ok",  64'(bus.move_ok),  64'd0);
        check("idle.move_err", 64'(bus.move_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/square_grid.md
SQUARE_GRID -- requirements
Module: square_grid

Interface
REQ-001 Parameter N, default 3, meaning grid side length; the grid holds N*N cells and N SHALL be 2 to 8.
REQ-002 Parameter CODE_W, default $clog2(N*N), meaning the cell-address width.
REQ-003 Port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port code  in  CODE_W  target cell index, row-major, cell r*N+c.
REQ-006 Port sel  in  1  move strobe, sampled each rising edge.
REQ-007 Port pl  in  1  requesting player: 0 = P0, 1 = P1.
REQ-008 Port clr  in  1  synchronous new-game request.
REQ-009 Port out  out  2*N*N  board state; cell i occupies bits [2i+1:2i], encoded 00 empty, 01 P0, 10 P1.
REQ-010 Port turn  out  1  player whose move is currently legal.
REQ-011 Port move_ok  out  1  one-cycle pulse when a move is accepted.
REQ-012 Port move_err  out  1  one-cycle pulse when a move is rejected.
REQ-013 Port winner  out  2  encoded 00 none, 01 P0, 10 P1.
REQ-014 Port done  out  1  high in the WIN and DRAW states.

Function
REQ-015 The block SHALL use a state machine with states PLAY, WIN and DRAW; the state after reset and after clr SHALL be PLAY.
REQ-016 A move is legal when all of the following hold at a sampling edge: state PLAY, sel=1, clr=0, code<N*N, the addressed cell is empty, and pl==turn.
REQ-017 On the edge that samples a legal move, the addressed cell SHALL be written 01 (pl=0) or 10 (pl=1), turn SHALL toggle, and move_ok SHALL be high for exactly the following cycle.
REQ-018 An illegal move (sel=1 with clr=0) SHALL leave out and turn unchanged and SHALL set move_err high for exactly the following cycle; this covers an occupied cell, code>=N*N, a wrong player, or a WIN/DRAW state.
REQ-019 move_ok and move_err SHALL never be high in the same cycle; with sel=0 both SHALL be 0 in the next cycle.
REQ-020 Win detection SHALL use the post-write board: any full row, full column, main diagonal or anti-diagonal owned by the mover SHALL transition PLAY->WIN on the same edge as the write.
REQ-021 winner SHALL equal the mover's encoding from that edge onward and SHALL hold until clr or reset.
REQ-022 If a legal move fills the last empty cell without a win, the state SHALL transition PLAY->DRAW on the same edge; a simultaneous win and full board SHALL go to WIN.
REQ-023 In WIN and DRAW, out, turn and winner SHALL be frozen until clr.
REQ-024 clr=1 SHALL, at the sampling edge, empty all cells, set turn=0, winner=00 and state=PLAY, and produce no move pulse; clr SHALL take priority over a simultaneous sel.
REQ-025 A move counter of width $clog2(N*N+1) SHALL track accepted moves and drive DRAW detection; it SHALL never wrap.

Reset
REQ-026 While rst=0, regardless of clk: out=0, turn=0, move_ok=0, move_err=0, winner=00, done=0, counter=0, state=PLAY.
REQ-027 A reset asserted mid-game SHALL discard the board immediately; the first edge after rst deasserts SHALL sample inputs normally.

Structure
REQ-028 Package square_pkg SHALL hold the cell_t encoding (EMPTY=2'b00, P0=2'b01, P1=2'b10) and the state_t enum (PLAY, WIN, DRAW).
REQ-029 Each cell SHALL be an instance of sub-module square_cell, parameterised by its index; square_cell holds a 2-bit register, decodes its own address match and exposes an occupied flag. square_grid SHALL contain the FSM, turn, counter and line-win logic as generate loops over N.

Verification (N=3)
REQ-030 rst=0 then release; sel=1, code=4, pl=0 -> next cycle move_ok=1, out[9:8]=01, turn=1.
REQ-031 P1 selects code=4 after P0 took it -> move_err=1, out unchanged, turn stays 1; then code=9 -> move_err=1.
REQ-032 P0 sends while turn=1 -> move_err=1, no cell changes.
REQ-033 P0 plays 0,1,2 with P1 playing 3,4 between them -> after the edge for P0's move to 2: winner=01, done=1; a further sel -> move_err=1.
REQ-034 A nine-move sequence with no line -> done=1, winner=00 (DRAW); clr=1 together with sel=1 -> out=0, turn=0, no pulse.
REQ-035 rst pulsed low mid-game between edges -> all outputs read 0 immediately, before any clock edge.
